// File: rtl/sha1_msg_padder_if.sv
// rtl/sha1_msg_padder_if.sv - word stream in, 512-bit padded block stream out
interface sha1_msg_padder_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         in_last;
  logic [1:0]   in_bytes;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic         busy;

  modport master (
    output in_valid, in_data, in_last, in_bytes, blk_ready,
    input  in_ready, blk_valid, blk_data, blk_first, blk_last, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, in_bytes, blk_ready,
    output in_ready, blk_valid, blk_data, blk_first, blk_last, busy
  );
endinterface

// File: rtl/sha1_msg_padder.sv
// rtl/sha1_msg_padder.sv - FIPS 180-4 message padder feeding 512-bit blocks to SHA1
module sha1_msg_padder #(
  parameter int LEN_BYTES_W = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  sha1_msg_padder_if.slave s_bus
);

  typedef enum logic [1:0] {ST_FILL, ST_PAD, ST_EMIT} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [31:0]            r_buf [16];
  logic [3:0]             r_widx;
  logic [LEN_BYTES_W-1:0] r_byte_cnt;
  logic                   r_pad80;
  logic                   r_padding;
  logic                   r_sent;
  logic                   r_blk_last;
  logic                   r_busy;

  logic                   w_in_ready;
  logic                   w_acc;
  logic                   w_hs;
  logic                   w_len_step;
  logic [31:0]            w_word;
  logic [LEN_BYTES_W-1:0] w_inc;
  logic [63:0]            w_len;
  logic [511:0]           w_blk;

  assign w_in_ready = (r_state == ST_FILL) && !wb_rst_i;
  assign w_acc      = s_bus.in_valid && w_in_ready;
  assign w_hs       = (r_state == ST_EMIT) && s_bus.blk_ready;
  assign w_len_step = (r_widx == 4'd14) && !r_pad80;
  assign w_len      = {{(61 - LEN_BYTES_W){1'b0}}, r_byte_cnt, 3'b000};

  // Partial last word: marker byte goes straight after the final valid byte.
  always_comb begin
    w_word = s_bus.in_data;
    w_inc  = LEN_BYTES_W'(4);
    if (s_bus.in_last) begin
      case (s_bus.in_bytes)
        2'd1: begin w_word = {s_bus.in_data[31:24], 24'h800000}; w_inc = LEN_BYTES_W'(1); end
        2'd2: begin w_word = {s_bus.in_data[31:16], 16'h8000};   w_inc = LEN_BYTES_W'(2); end
        2'd3: begin w_word = {s_bus.in_data[31:8],  8'h80};      w_inc = LEN_BYTES_W'(3); end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_blk = '0;
    for (int i = 0; i < 16; i++) begin
      w_blk[511 - 32*i -: 32] = r_buf[i];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_FILL: begin
        if (w_acc) begin
          if (r_widx == 4'd15)     w_state_nxt = ST_EMIT;
          else if (s_bus.in_last)  w_state_nxt = ST_PAD;
        end
      end
      ST_PAD: begin
        if (w_len_step || r_widx == 4'd15) w_state_nxt = ST_EMIT;
      end
      ST_EMIT: begin
        if (w_hs) begin
          if (r_padding && !r_blk_last) w_state_nxt = ST_PAD;
          else                          w_state_nxt = ST_FILL;
        end
      end
      default: w_state_nxt = ST_FILL;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state <= ST_FILL;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < 16; i++) r_buf[i] <= '0;
      r_widx     <= '0;
      r_byte_cnt <= '0;
      r_pad80    <= 1'b0;
      r_padding  <= 1'b0;
      r_sent     <= 1'b0;
      r_blk_last <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_acc) begin
            r_buf[r_widx] <= w_word;
            r_widx        <= r_widx + 4'd1;
            r_byte_cnt    <= r_byte_cnt + w_inc;
            r_busy        <= 1'b1;
            r_blk_last    <= 1'b0;
            if (s_bus.in_last) begin
              r_padding <= 1'b1;
              r_pad80   <= (s_bus.in_bytes == 2'd0);
            end
          end
        end
        ST_PAD: begin
          if (w_len_step) begin
            r_buf[14]  <= w_len[63:32];
            r_buf[15]  <= w_len[31:0];
            r_blk_last <= 1'b1;
          end else begin
            r_buf[r_widx] <= r_pad80 ? 32'h8000_0000 : 32'h0;
            r_pad80       <= 1'b0;
            r_widx        <= r_widx + 4'd1;
            r_blk_last    <= 1'b0;
          end
        end
        ST_EMIT: begin
          if (w_hs) begin
            r_widx <= '0;
            r_sent <= 1'b1;
            // Length-bearing block accepted: message done, re-arm for the next one.
            if (r_padding && r_blk_last) begin
              r_padding  <= 1'b0;
              r_byte_cnt <= '0;
              r_busy     <= 1'b0;
              r_sent     <= 1'b0;
              r_blk_last <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign s_bus.in_ready  = w_in_ready;
  assign s_bus.blk_valid = (r_state == ST_EMIT);
  assign s_bus.blk_first = (r_state == ST_EMIT) && !r_sent;
  assign s_bus.blk_last  = r_blk_last;
  assign s_bus.blk_data  = w_blk;
  assign s_bus.busy      = r_busy;

endmodule

// File: tb/tb_sha1_msg_padder.sv
// tb/tb_sha1_msg_padder.sv - directed self-checking bench for sha1_msg_padder
module tb_sha1_msg_padder;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;
  logic [31:0]  ew [16];
  logic [511:0] got_d;
  logic         got_f;
  logic         got_l;
  int           lat;

  sha1_msg_padder_if bus ();

  sha1_msg_padder #(.LEN_BYTES_W(32)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .s_bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] wd(input int i);
    return 32'hC0DE_0000 | 32'(i);
  endfunction

  function automatic logic [511:0] pack_ew();
    logic [511:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) r[511 - 32*i -: 32] = ew[i];
    return r;
  endfunction

  task automatic clear_ew();
    for (int i = 0; i < 16; i++) ew[i] = 32'h0;
  endtask

  task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
    int n;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_bytes = nb;
    n = 0;
    while (!bus.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic send_msg(input int nw, input logic [31:0] lastw, input logic [1:0] nb);
    for (int i = 0; i < nw - 1; i++) send(wd(i), 1'b0, 2'd0);
    send(lastw, 1'b1, nb);
  endtask

  // Counts cycles from the call until blk_valid, then captures the block.
  task automatic wait_blk(output int cycles);
    cycles = 0;
    while (!bus.blk_valid && cycles < 200) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    if (cycles >= 200) chk("blk_timeout", 0, 1);
    got_d = bus.blk_data;
    got_f = bus.blk_first;
    got_l = bus.blk_last;
  endtask

  task automatic take_blk();
    @(negedge clk);
    bus.blk_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.blk_ready = 1'b0;
  endtask

  task automatic abc_expect();
    clear_ew();
    ew[0]  = 32'h6162_6380;
    ew[15] = 32'h0000_0018;
  endtask

  initial begin
    bit saw_valid;
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_bytes  = '0;
    bus.blk_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_blk_valid", bus.blk_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_blk_first", bus.blk_first, 0);
    chk("rst_blk_last",  bus.blk_last,  0);
    chk("rst_blk_data",  bus.blk_data,  0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);

    // "abc"
    send(32'h6162_6300, 1'b1, 2'd3);
    chk("abc_busy", bus.busy, 1);
    wait_blk(lat);
    abc_expect();
    chk("abc_latency", lat, 14);
    chk("abc_data",  got_d, pack_ew());
    chk("abc_first", got_f, 1);
    chk("abc_last",  got_l, 1);
    take_blk();
    chk("abc_busy_done", bus.busy, 0);

    // 55 bytes
    send_msg(14, 32'hDEAD_BEEF, 2'd3);
    wait_blk(lat);
    clear_ew();
    for (int i = 0; i < 13; i++) ew[i] = wd(i);
    ew[13] = 32'hDEAD_BE80;
    ew[15] = 32'h0000_01B8;
    chk("m55_latency", lat, 1);
    chk("m55_data",  got_d, pack_ew());
    chk("m55_first", got_f, 1);
    chk("m55_last",  got_l, 1);
    take_blk();

    // 56 bytes: marker spills, length needs a second block
    send_msg(14, wd(13), 2'd0);
    wait_blk(lat);
    clear_ew();
    for (int i = 0; i < 14; i++) ew[i] = wd(i);
    ew[14] = 32'h8000_0000;
    chk("m56_b1_data",  got_d, pack_ew());
    chk("m56_b1_first", got_f, 1);
    chk("m56_b1_last",  got_l, 0);
    take_blk();
    wait_blk(lat);
    clear_ew();
    ew[15] = 32'h0000_01C0;
    chk("m56_b2_data",  got_d, pack_ew());
    chk("m56_b2_first", got_f, 0);
    chk("m56_b2_last",  got_l, 1);
    take_blk();

    // 64 bytes: full data block then pure padding block
    send_msg(16, wd(15), 2'd0);
    wait_blk(lat);
    for (int i = 0; i < 16; i++) ew[i] = wd(i);
    chk("m64_b1_data",  got_d, pack_ew());
    chk("m64_b1_first", got_f, 1);
    chk("m64_b1_last",  got_l, 0);
    take_blk();
    wait_blk(lat);
    clear_ew();
    ew[0]  = 32'h8000_0000;
    ew[15] = 32'h0000_0200;
    chk("m64_b2_data",  got_d, pack_ew());
    chk("m64_b2_first", got_f, 0);
    chk("m64_b2_last",  got_l, 1);
    take_blk();

    // Backpressure on EMIT with a pending input word
    send(32'h6162_6300, 1'b1, 2'd3);
    wait_blk(lat);
    abc_expect();
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h6162_6300;
    bus.in_last  = 1'b1;
    bus.in_bytes = 2'd3;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("bp_data_%0d", c),  bus.blk_data,  pack_ew());
      chk($sformatf("bp_valid_%0d", c), bus.blk_valid, 1);
      chk($sformatf("bp_ready_%0d", c), bus.in_ready,  0);
      chk($sformatf("bp_flags_%0d", c), {bus.blk_first, bus.blk_last}, 2'b11);
    end
    bus.in_valid = 1'b0;
    take_blk();
    send(32'h6162_6300, 1'b1, 2'd3);
    wait_blk(lat);
    chk("bp_next_first", got_f, 1);
    chk("bp_next_data",  got_d, pack_ew());
    take_blk();

    // Reset while padding: nothing must come out, length must restart
    send(32'h6162_6300, 1'b1, 2'd3);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    saw_valid = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.blk_valid) saw_valid = 1'b1;
    end
    chk("rstpad_no_valid", saw_valid, 0);
    chk("rstpad_busy", bus.busy, 0);
    send(32'h6162_6300, 1'b1, 2'd3);
    wait_blk(lat);
    abc_expect();
    chk("rstpad_data",  got_d, pack_ew());
    chk("rstpad_first", got_f, 1);
    take_blk();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
